// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: word/array sizes, magic constants and the
// key-mixing state encoding used by the key schedule blocks.
package rc5_pkg;

   localparam int W        = 32;
   localparam int T        = 26;
   localparam int C        = 4;
   localparam int T_LENGTH = $clog2(T);
   localparam int C_LENGTH = $clog2(C);

   // Magic constants for 32-bit words (odd(e-2)*2^32, odd(phi-1)*2^32)
   localparam logic [31:0] P32 = 32'hB7E15163;
   localparam logic [31:0] Q32 = 32'h9E3779B9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      MIX_A = 2'd2,
      MIX_B = 2'd3
   } state_t;

   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/rotl_var.sv
// Combinational w-bit left rotate by a variable amount.
module rotl_var #(
   parameter int w        = 32,
   parameter int a_length = $clog2(w)
) (
   input  logic [w-1:0]        value,
   input  logic [a_length-1:0] amount,
   output logic [w-1:0]        result
);

   logic [2*w-1:0] doubled;

   // Shift a doubled copy; the upper half holds the wrapped-around bits
   always_comb begin
      doubled = {value, value} << amount;
      result  = doubled[2*w-1:w];
   end

endmodule

// File: rtl/key_mix_loop.sv
// RC5 key-schedule mixing loop: 3*max(t,c) iterations of
// A = S[i] = rotl(S[i]+A+B, 3); B = L[j] = rotl(L[j]+A+B, A+B),
// three cycles each, against external synchronous-read S and L arrays.
module key_mix_loop
   import rc5_pkg::*;
#(
   parameter int w        = W,
   parameter int t        = T,
   parameter int c        = C,
   parameter int t_length = $clog2(t),
   parameter int c_length = $clog2(c)
) (
   input  logic                clk1,
   input  logic                rst,
   input  logic                start,
   output logic [t_length-1:0] S_address,
   input  logic [w-1:0]        S_sub_i,
   output logic [w-1:0]        S_sub_i_prima,
   output logic                S_we,
   output logic [c_length-1:0] L_address,
   input  logic [w-1:0]        L_sub_i,
   output logic [w-1:0]        L_sub_i_prima,
   output logic                L_we,
   output logic                busy,
   output logic                done
);

   localparam int rot_length = $clog2(w);
   localparam int k_limit    = 3 * max_int(t, c);
   localparam int k_length   = $clog2(k_limit + 1);

   state_t              state, state_next;
   logic [w-1:0]        a_reg, b_reg, l_reg;
   logic [t_length-1:0] i_reg;
   logic [c_length-1:0] j_reg;
   logic [k_length-1:0] k_reg;
   logic                done_reg;

   logic [w-1:0]        a_sum, ab_sum, b_sum, a_new, b_new;
   logic                last_iter;

   assign a_sum     = S_sub_i + a_reg + b_reg;
   assign ab_sum    = a_reg + b_reg;
   assign b_sum     = l_reg + ab_sum;
   assign last_iter = (k_reg == k_length'(k_limit - 1));

   rotl_var #(.w(w)) u_rot_a (
      .value  (a_sum),
      .amount (rot_length'(3)),
      .result (a_new)
   );

   rotl_var #(.w(w)) u_rot_b (
      .value  (b_sum),
      .amount (ab_sum[rot_length-1:0]),
      .result (b_new)
   );

   // State register
   always_ff @(posedge clk1) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: READ -> MIX_A -> MIX_B, looping until k is exhausted
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = READ;
         READ:    state_next = MIX_A;
         MIX_A:   state_next = MIX_B;
         MIX_B:   state_next = last_iter ? IDLE : READ;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: addresses follow i/j all iteration, write data only while enabled
   always_comb begin
      busy          = (state != IDLE);
      S_we          = (state == MIX_A);
      L_we          = (state == MIX_B);
      S_address     = i_reg;
      L_address     = j_reg;
      S_sub_i_prima = S_we ? a_new : '0;
      L_sub_i_prima = L_we ? b_new : '0;
      done          = done_reg;
   end

   // Datapath: A/B accumulators, captured L word, and the i/j/k indices
   always_ff @(posedge clk1) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         l_reg    <= '0;
         i_reg    <= '0;
         j_reg    <= '0;
         k_reg    <= '0;
         done_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg    <= '0;
                  b_reg    <= '0;
                  i_reg    <= '0;
                  j_reg    <= '0;
                  k_reg    <= '0;
                  done_reg <= 1'b0;
               end
            end
            MIX_A: begin
               a_reg <= a_new;
               l_reg <= L_sub_i;
            end
            MIX_B: begin
               b_reg <= b_new;
               i_reg <= (i_reg == t_length'(t - 1)) ? '0 : i_reg + 1'b1;
               j_reg <= (j_reg == c_length'(c - 1)) ? '0 : j_reg + 1'b1;
               k_reg <= k_reg + 1'b1;
               if (last_iter) done_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_key_mix_loop.sv
// Bench for key_mix_loop: models the S/L arrays, predicts every write from a
// plain software RC5 key schedule, and checks outputs every cycle.
module tb_key_mix_loop;

   localparam int W   = 32;
   localparam int T   = 26;
   localparam int C   = 4;
   localparam int TL  = 5;
   localparam int CL  = 2;
   localparam int K   = 3 * 26;
   localparam int LAT = 1 + 9 * 26;

   logic          clk1  = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic [TL-1:0] S_address;
   logic [W-1:0]  S_sub_i = '0;
   logic [W-1:0]  S_sub_i_prima;
   logic          S_we;
   logic [CL-1:0] L_address;
   logic [W-1:0]  L_sub_i = '0;
   logic [W-1:0]  L_sub_i_prima;
   logic          L_we;
   logic          busy;
   logic          done;

   always #5 clk1 = ~clk1;

   key_mix_loop dut (
      .clk1          (clk1),
      .rst           (rst),
      .start         (start),
      .S_address     (S_address),
      .S_sub_i       (S_sub_i),
      .S_sub_i_prima (S_sub_i_prima),
      .S_we          (S_we),
      .L_address     (L_address),
      .L_sub_i       (L_sub_i),
      .L_sub_i_prima (L_sub_i_prima),
      .L_we          (L_we),
      .busy          (busy),
      .done          (done)
   );

   logic [31:0] smem [T];
   logic [31:0] lmem [C];
   logic [31:0] es [K];
   logic [31:0] el [K];
   logic [31:0] sf [T];
   logic [31:0] lf [C];
   logic [31:0] obs_sa [K];
   logic [31:0] obs_la [K];

   int checks    = 0;
   int errors    = 0;
   int cyc       = -1;
   bit exp_done  = 1'b0;
   int busy_cnt  = 0;
   int sw_cnt    = 0;
   int lw_cnt    = 0;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} << (n % 32);
      return d[63:32];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Software key schedule over a snapshot of the arrays
   task automatic build_model();
      logic [31:0] a, b;
      int i, j;
      for (int x = 0; x < T; x++) sf[x] = smem[x];
      for (int x = 0; x < C; x++) lf[x] = lmem[x];
      a = 0; b = 0; i = 0; j = 0;
      for (int k = 0; k < K; k++) begin
         a = rotl(sf[i] + a + b, 3);
         sf[i] = a;
         es[k] = a;
         b = rotl(lf[j] + a + b, int'((a + b) % 32));
         lf[j] = b;
         el[k] = b;
         i = (i + 1) % T;
         j = (j + 1) % C;
      end
   endtask

   // One clock: memory responds to what was presented, model advances, then compare
   task automatic tick();
      logic          sw, lw, st_s, rst_s;
      logic [TL-1:0] sa;
      logic [CL-1:0] la;
      logic [31:0]   sd, ld;
      int            m, ph;
      sw = S_we; lw = L_we; sa = S_address; la = L_address;
      sd = S_sub_i_prima; ld = L_sub_i_prima; st_s = start; rst_s = rst;
      @(posedge clk1);
      #1;
      S_sub_i = (!$isunknown(sa) && int'(sa) < T) ? smem[sa] : '0;
      L_sub_i = (!$isunknown(la)) ? lmem[la] : '0;
      if (sw === 1'b1 && int'(sa) < T) smem[sa] = sd;
      if (lw === 1'b1) lmem[la] = ld;
      if (rst_s) begin
         cyc = -1; exp_done = 1'b0;
      end else if (cyc < 0) begin
         if (st_s) begin cyc = 1; exp_done = 1'b0; end
      end else begin
         cyc++;
         if (cyc == 3 * K + 1) begin cyc = -1; exp_done = 1'b1; end
      end
      @(negedge clk1);
      ph = (cyc > 0) ? (cyc - 1) % 3 : -1;
      m  = (cyc > 0) ? (cyc - 1) / 3 : 0;
      check("busy", busy, cyc > 0);
      check("done", done, exp_done);
      check("S_we", S_we, ph == 1);
      check("L_we", L_we, ph == 2);
      if (S_we && L_we) check("we_exclusive", 1, 0);
      if (cyc > 0) begin
         check("S_address", S_address, m % T);
         check("L_address", L_address, m % C);
         if (ph == 0) begin obs_sa[m] = S_address; obs_la[m] = L_address; end
         if (ph == 1 && S_we) check("S_wdata", S_sub_i_prima, es[m]);
         if (ph == 2 && L_we) check("L_wdata", L_sub_i_prima, el[m]);
      end
      if (busy) busy_cnt++;
      if (S_we) sw_cnt++;
      if (L_we) lw_cnt++;
   endtask

   // Full run from a start pulse, optionally re-pulsing start mid-run
   task automatic run_full(input string tag, input int restart_at);
      int done_cycle;
      build_model();
      busy_cnt = 0; sw_cnt = 0; lw_cnt = 0; done_cycle = -1;
      start = 1'b1; tick(); start = 1'b0;
      for (int cy = 1; cy <= LAT + 40; cy++) begin
         if (done === 1'b1) begin done_cycle = cy; break; end
         if (cy == restart_at) start = 1'b1;
         tick();
         start = 1'b0;
      end
      check({tag, "_latency"}, done_cycle, LAT);
      check({tag, "_busy_cycles"}, busy_cnt, LAT - 1);
      check({tag, "_S_writes"}, sw_cnt, K);
      check({tag, "_L_writes"}, lw_cnt, K);
      for (int x = 0; x < T; x++) check({tag, "_S_final"}, smem[x], sf[x]);
      for (int x = 0; x < C; x++) check({tag, "_L_final"}, lmem[x], lf[x]);
      $display("run %s: done at cycle %0d, S writes %0d, L writes %0d", tag, done_cycle, sw_cnt, lw_cnt);
   endtask

   initial begin
      logic [31:0] a, b;
      int sw_before;

      for (int x = 0; x < T; x++) smem[x] = $urandom;
      for (int x = 0; x < C; x++) lmem[x] = $urandom;

      // Reset
      rst = 1'b1;
      @(negedge clk1);
      repeat (3) tick();
      rst = 1'b0;
      check("rst_S_address", S_address, 0);
      check("rst_L_address", L_address, 0);
      check("rst_S_wdata", S_sub_i_prima, 0);
      check("rst_L_wdata", L_sub_i_prima, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (2) tick();

      // First iteration with S[0]=1, L[0]=0
      smem[0] = 32'h1; lmem[0] = 32'h0;
      build_model();
      check("model_first_S", es[0], 32'h00000008);
      check("model_first_L", el[0], 32'h00000800);
      run_full("first_iter", -1);

      // Golden P/Q schedule with all-zero key, start re-pulsed at cycle 50
      smem[0] = 32'hB7E15163;
      for (int x = 1; x < T; x++) smem[x] = smem[x-1] + 32'h9E3779B9;
      for (int x = 0; x < C; x++) lmem[x] = 32'h0;
      repeat (3) tick();
      run_full("golden", 50);
      check("wrap27_S_address", obs_sa[26], 0);
      check("wrap27_L_address", obs_la[26], 2);
      check("wrap5_L_address", obs_la[4], 0);
      // Encrypt a zero block with the produced table: known RC5-32/12/16 vector
      a = smem[0]; b = smem[1];
      for (int r = 1; r <= 12; r++) begin
         a = rotl(a ^ b, int'(b % 32)) + smem[2*r];
         b = rotl(b ^ a, int'(a % 32)) + smem[2*r+1];
      end
      check("rc5_ct_A", a, 32'hEEDBA521);
      check("rc5_ct_B", b, 32'h6D8F4B15);

      // Random array contents and idle gaps
      for (int n = 0; n < 3; n++) begin
         for (int x = 0; x < T; x++) smem[x] = $urandom;
         for (int x = 0; x < C; x++) lmem[x] = $urandom;
         repeat ($urandom_range(1, 6)) tick();
         run_full("random", -1);
      end

      // Reset in cycle 100 of the loop
      build_model();
      start = 1'b1; tick(); start = 1'b0;
      for (int cy = 1; cy < 100; cy++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_S_address", S_address, 0);
      check("midrst_L_address", L_address, 0);
      sw_before = sw_cnt + lw_cnt;
      repeat (20) tick();
      check("midrst_no_writes", sw_cnt + lw_cnt, sw_before);
      $display("run midrst: reset in cycle 100, writes before reset %0d", sw_before);
      run_full("after_rst", -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_mix_loop.md
KEY_MIX_LOOP -- requirements
Module: key_mix_loop

Interface
REQ-001 SHALL have parameter w, default 32, data word width in bits.
REQ-002 SHALL have parameter t, default 26, S array length (2r+2).
REQ-003 SHALL have parameter c, default 4, L array length (b/u).
REQ-004 SHALL have parameters t_length = $clog2(t) and c_length = $clog2(c), used as address widths.
REQ-005 SHALL have one clock: clk1, input, 1 bit, rising-edge clock for all state.
REQ-006 SHALL have rst, input, 1 bit, reset that is synchronous and active-high.
REQ-007 SHALL have start, input, 1 bit, one-cycle request to begin mixing.
REQ-008 SHALL have S_address, output, t_length bits, S array read/write address.
REQ-009 SHALL have S_sub_i, input, w bits, S read data, valid the cycle after S_address is presented.
REQ-010 SHALL have S_sub_i_prima, output, w bits, S write data.
REQ-011 SHALL have S_we, output, 1 bit, S write enable.
REQ-012 SHALL have L_address, output, c_length bits, L array read/write address.
REQ-013 SHALL have L_sub_i, input, w bits, L read data, valid the cycle after L_address is presented.
REQ-014 SHALL have L_sub_i_prima, output, w bits, L write data.
REQ-015 SHALL have L_we, output, 1 bit, L write enable.
REQ-016 SHALL have busy, output, 1 bit, high while mixing.
REQ-017 SHALL have done, output, 1 bit, level that is high from completion until the next accepted start.

Function
REQ-018 SHALL implement the states IDLE, READ, MIX_A and MIX_B.
REQ-019 In IDLE, start SHALL clear A, B, i, j and k, clear done, and move to READ on the next edge.
REQ-020 In READ, the block SHALL drive S_address=i and L_address=j, with both write enables low.
REQ-021 In MIX_A, the block SHALL compute A'=rotl(S_sub_i+A+B, 3) mod 2^w, write it to S[i] (S_we=1), register A=A', and capture L_sub_i into a register.
REQ-022 In MIX_B, the block SHALL compute B'=rotl(Lreg+A+B, (A+B) mod w) and write it to L[j] (L_we=1).
REQ-023 In MIX_B, the block SHALL also register B=B', step i=(i+1) mod t, j=(j+1) mod c and k=k+1.
REQ-024 At the end of MIX_B, the block SHALL go to IDLE with done=1 if k reaches 3*max(t,c), otherwise to READ.
REQ-025 All additions SHALL wrap modulo 2^w, and the rotate amount SHALL be the low $clog2(w) bits of the sum.
REQ-026 Each iteration SHALL take exactly 3 cycles, so total latency from the start edge to done high is 1+9*max(t,c) cycles (235 at defaults).
REQ-027 start while busy SHALL be ignored.
REQ-028 S_address and L_address SHALL be held stable through READ, MIX_A and MIX_B of an iteration.
REQ-029 The i wrap (t-1 to 0) and the j wrap (c-1 to 0) SHALL occur in the same cycle when coincident.
REQ-030 S_we and L_we SHALL never be high in the same cycle.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL enter IDLE with A=B=0, i=j=k=0, done=0, S_we=L_we=0, S/L addresses 0 and write data 0.
REQ-033 rst SHALL take priority over start and over any in-progress iteration; a reset mid-operation SHALL abandon the loop with no further writes.

Structure
REQ-034 Parameters w, t, c, the derived lengths, the P/Q magic constants and the state encoding SHALL live in a shared rc5_pkg package used by the init blocks and this block.
REQ-035 One sub-module, rotl_var (w-bit variable left rotate, combinational), SHALL be instantiated twice: once with a constant 3, once with the data-dependent amount.

Verification
REQ-036 First iteration: S[0]=0x00000001, L[0]=0, start -> S[0] written as 0x00000008, then L[0] written as 0x00000800.
REQ-037 Latency: start pulse at cycle 0 with defaults -> busy high cycles 1..234, done rises at cycle 235, S_we pulses 78 times and L_we pulses 78 times.
REQ-038 Wrap: observe iteration 27 -> S_address=0 and L_address=2; observe iteration 5 -> L_address=0.
REQ-039 Golden model: S initialised with P/Q and L from an all-zero 16-byte key, start -> final S and L match a software RC5-32/12/16 key schedule word for word.
REQ-040 Reset: rst asserted at cycle 100 of the loop -> next cycle IDLE, busy=0, done=0, no write enable afterwards; start again -> full 235-cycle run.
REQ-041 Ignored start: start re-pulsed at cycle 50 -> no restart and unchanged completion cycle.
